// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational mini ALU between two requesters
// Sequences accept -> drive operands for ALU_LAT cycles -> hold result until the owner consumes it.
module alu_share_arbiter #(
  parameter int WIDTH   = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_g,
  output logic             rsp0_carry,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_g,
  output logic             rsp1_carry,
  output logic             alu_s1,
  output logic             alu_s0,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_g,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] g0_q, g0_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic             c0_q, c0_d;
  logic             c1_q, c1_d;
  logic             grant0, grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      owner_q <= 1'b0;
      g0_q    <= '0;
      g1_q    <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      owner_q <= owner_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    owner_d    = owner_q;
    g0_d       = g0_q;
    g1_d       = g1_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_s1     = 1'b0;
    alu_s0     = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    // On contention the port equal to the pointer wins; a lone requester always wins.
    grant0     = req0_valid && (!req1_valid || !rr_q);
    grant1     = req1_valid && (!req0_valid || rr_q);

    case (state_q)
      IDLE: begin
        // Ready is combinational, so it is forced low while reset is held.
        req0_ready = rst_n && grant0;
        req1_ready = rst_n && grant1;
        if (grant0 || grant1) begin
          owner_d = grant1;
          op_d    = grant1 ? req1_op : req0_op;
          a_d     = grant1 ? req1_a  : req0_a;
          b_d     = grant1 ? req1_b  : req0_b;
          cnt_d   = CNT_LOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        alu_s1 = op_q[1];
        alu_s0 = op_q[0];
        alu_a  = a_q;
        alu_b  = b_q;
        if (cnt_q == 4'd0) begin
          if (owner_q) begin
            g1_d = alu_g;
            c1_d = alu_carry;
          end else begin
            g0_d = alu_g;
            c0_d = alu_carry;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // The pointer moves only when a response completes, giving 0,1,0,1 under load.
        if (owner_q) begin
          rsp1_valid = 1'b1;
          if (rsp1_ready) begin
            rr_d    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          rsp0_valid = 1'b1;
          if (rsp0_ready) begin
            rr_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp0_g     = g0_q;
  assign rsp0_carry = c0_q;
  assign rsp1_g     = g1_q;
  assign rsp1_carry = c1_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 3-bit mini arithmetic unit between two requesters (port 0, port 1) using round-robin arbitration. It accepts one operation at a time over a valid/ready request channel and drives the unit's select and operand lines. It waits a programmable settle time, captures G and carry, and returns them on the winning requester's response channel. The arithmetic unit itself stays combinational and external; this block provides all sequencing around it.

Parameters:
WIDTH, 3, operand/result width; must match the arithmetic unit.
ALU_LAT, 1, cycles operands are held on the unit before G/carry are sampled; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_op  in  2  {s1,s0}: 00 A-1, 01 A+B, 10 A-B, 11 -B
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 result consumed
rsp0_g  out  WIDTH  result G
rsp0_carry  out  1  carry out
req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_g, rsp1_carry: same widths and meanings, port 1
alu_s1  out  1  unit select high
alu_s0  out  1  unit select low
alu_a  out  WIDTH  unit operand A
alu_b  out  WIDTH  unit operand B
alu_g  in  WIDTH  unit result G
alu_carry  in  1  unit carry

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr pointer=0, settle counter=0, captured op/A/B=0, owner=0. All outputs are 0, including every ready/valid, alu_*, rspN_g and rspN_carry. Asserting reset mid-transaction discards it with no response.
- States: IDLE, DRIVE, RESP.
- IDLE: reqN_ready is combinational.
  - Only one valid: that port gets ready=1.
  - Both valid: the port equal to the rr pointer wins. The other sees ready=0 and must hold its request.
  - Neither valid: both ready=0.
  - On handshake (valid&&ready): capture op/A/B and owner, load counter=ALU_LAT-1, go to DRIVE.
- DRIVE: alu_s1/alu_s0/alu_a/alu_b come from the captured registers (0 in IDLE and RESP). Both reqN_ready=0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, register alu_g and alu_carry into the owner's rsp_g/rsp_carry, then go to RESP.
- RESP: the owner's rsp_valid=1. rsp_g and rsp_carry stay stable until the handshake. The non-owner's rsp_valid=0.
  - On rsp_ready=1: clear rsp_valid, set rr pointer to the other port (~owner), go to IDLE.
  - rsp_g/rsp_carry keep their last values after the handshake and are meaningful only while rsp_valid=1.
- Latency: handshake at cycle T, alu_* driven in cycles T+1..T+ALU_LAT, rsp_valid first high at T+ALU_LAT+1. With rsp_ready tied high, the next acceptance is possible at T+ALU_LAT+2.
- The pointer updates only on response completion. Back-to-back contention therefore alternates 0,1,0,1.
- A requester that keeps valid high while losing is not dropped. It wins the next arbitration.
- Request fields are sampled only on handshake. Changes to them afterwards have no effect.
- Carry is passed through exactly as the unit produces it. No width extension or overflow detection happens here.
- rsp_ready asserted outside RESP is ignored.

Test Plan:
- Reset then single add: req0 op=01 A=011 B=010, ALU_LAT=1 -> req0_ready=1 at T; alu_s1/s0=0/1, alu_a=011, alu_b=010 at T+1; rsp0_valid=1 with g=101, carry=0 at T+2.
- Subtract/negate on port 1: op=10 A=000 B=000 -> rsp1 g=000, carry=1. Then op=11 B=001 -> rsp1 g=111, carry=0. Then op=00 A=000 -> g=111, carry=0.
- Contention: both valid at the same cycle after reset -> port 0 is served first and port 1 next. Then both valid again -> port 0 is served first, then port 1. Ready is never high on both ports in the same cycle.
- Response backpressure: hold rsp0_ready=0 for 5 cycles -> rsp0_valid and g/carry stay stable, both req_ready=0, alu_* stay 0. Release -> back to IDLE next cycle.
- ALU_LAT=4: alu_* are held constant for exactly 4 cycles and rsp_valid asserts at T+5. The bench's unit model changes G mid-window, and the captured value is the one present at the last DRIVE cycle.
- Reset mid-DRIVE and mid-RESP: all outputs are 0 immediately (asynchronously), no response is emitted, and the next request is served by port 0 priority.
